// File: rtl/operand_triple_loader_pkg.sv
// ---------------------------------------------------------------------------
// operand_triple_loader_pkg
//   Shared types for the operand triple loader: the load-side FSM that frames
//   the serial a/b/c word stream, the output-side FSM that commits triples to
//   the datapath, and a helper sizing the latency counter.
// ---------------------------------------------------------------------------
package operand_triple_loader_pkg;

  // Load side: which operand the next accepted word fills. FULL means a
  // complete triple sits in staging waiting to be committed.
  typedef enum logic [1:0] {
    LD_A = 2'd0,
    LD_B = 2'd1,
    LD_C = 2'd2,
    FULL = 2'd3
  } ld_state_t;

  // Output side: IDLE (nothing in flight), WAIT (datapath settling after a
  // commit), HOLD (res_valid up, waiting for the consumer).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } out_state_t;

  localparam int DATAWIDTH_DEF  = 64;
  localparam int DP_LATENCY_DEF = 2;

  // Counter width able to hold DP_LATENCY; never below one bit so an illegal
  // latency still elaborates far enough to hit the explicit error.
  function automatic int lat_cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/operand_triple_loader_latency_timer.sv
// ---------------------------------------------------------------------------
// operand_triple_loader_latency_timer
//   Counts the datapath settling time after a commit. Loading sets the count
//   to DP_LATENCY; it then decrements once per edge and stops at zero.
//   o_done is high in the cycle whose closing edge takes the count to zero,
//   i.e. the edge after which the datapath x/z registers hold the result.
// Ports
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset (count -> 0)
//   i_load  in   restart the count at DP_LATENCY
//   o_done  out  this edge completes the latency window
// ---------------------------------------------------------------------------
module operand_triple_loader_latency_timer
  import operand_triple_loader_pkg::*;
#(
  parameter int DP_LATENCY = DP_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_done
);

  localparam int CW = lat_cnt_w(DP_LATENCY);

  // A zero-latency datapath would need a combinational commit->result path,
  // which this block does not provide.
  generate
    if (DP_LATENCY < 1) begin : g_bad_latency
      $error("operand_triple_loader: DP_LATENCY must be at least 1");
    end
  endgenerate

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(DP_LATENCY);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done = (r_cnt == CW'(1)) && !i_load;

endmodule

// File: rtl/operand_triple_loader.sv
// ---------------------------------------------------------------------------
// operand_triple_loader
//   Upstream feeder for the generated s4 datapath. Operand words arrive one at
//   a time (a, then b, then c) on a valid/ready stream; in_first tags word a.
//   Words are framed into a staging triple; a complete triple is committed to
//   a/b/c in a single edge and held stable until the next commit, because the
//   datapath has no enable of its own. res_valid rises once the datapath
//   output registers reflect the committed triple and stays up until taken.
//   Staging of the next triple overlaps the WAIT/HOLD of the current one.
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_data    in   operand word, two's complement
//   in_first   in   word is operand a
//   in_valid   in   in_data/in_first valid
//   in_ready   out  a word can be accepted this cycle (not a function of in_valid)
//   a, b, c    out  committed operands to the datapath, registered
//   res_valid  out  datapath x/z correspond to a/b/c
//   res_ready  in   consumer takes x/z this cycle
//   seq_err    out  sticky framing-violation flag, cleared only by rst
// ---------------------------------------------------------------------------
module operand_triple_loader
  import operand_triple_loader_pkg::*;
#(
  parameter int DATAWIDTH  = DATAWIDTH_DEF,
  parameter int DP_LATENCY = DP_LATENCY_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATAWIDTH-1:0]        in_data,
  input  logic                        in_first,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [DATAWIDTH-1:0] a,
  output logic signed [DATAWIDTH-1:0] b,
  output logic signed [DATAWIDTH-1:0] c,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        seq_err
);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  ld_state_t            r_ld_state;
  ld_state_t            w_ld_next;
  out_state_t           r_out_state;
  out_state_t           w_out_next;

  logic [DATAWIDTH-1:0] r_stage_a;
  logic [DATAWIDTH-1:0] r_stage_b;
  logic [DATAWIDTH-1:0] r_stage_c;
  logic [DATAWIDTH-1:0] r_a;
  logic [DATAWIDTH-1:0] r_b;
  logic [DATAWIDTH-1:0] r_c;
  logic                 r_res_valid;
  logic                 r_seq_err;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_ld_a;
  logic                 w_ld_b;
  logic                 w_ld_c;
  logic                 w_set_err;
  logic                 w_commit;
  logic                 w_rv_set;
  logic                 w_rv_clr;
  logic                 w_timer_done;
  logic                 w_full;

  // Ready depends only on registered state and rst, so in_valid never loops
  // back into in_ready. Holding it low during rst makes in_valid inert there.
  assign w_full     = (r_ld_state == FULL);
  assign w_in_ready = !rst && !w_full;
  assign w_accept   = in_valid && w_in_ready;

  // -------------------------------------------------------------------------
  // Load FSM: frames the word stream into stage_a/b/c
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_state <= LD_A;
    end else begin
      r_ld_state <= w_ld_next;
    end
  end

  always_comb begin
    w_ld_next = r_ld_state;
    w_ld_a    = 1'b0;
    w_ld_b    = 1'b0;
    w_ld_c    = 1'b0;
    w_set_err = 1'b0;
    unique case (r_ld_state)
      LD_A: begin
        if (w_accept) begin
          if (in_first) begin
            w_ld_a    = 1'b1;
            w_ld_next = LD_B;
          end else begin
            // No start marker yet: the word belongs to no triple.
            w_set_err = 1'b1;
          end
        end
      end
      LD_B: begin
        if (w_accept) begin
          if (in_first) begin
            // Early start marker: restart the triple from this word.
            w_ld_a    = 1'b1;
            w_set_err = 1'b1;
          end else begin
            w_ld_b    = 1'b1;
            w_ld_next = LD_C;
          end
        end
      end
      LD_C: begin
        if (w_accept) begin
          if (in_first) begin
            w_ld_a    = 1'b1;
            w_set_err = 1'b1;
            w_ld_next = LD_B;
          end else begin
            w_ld_c    = 1'b1;
            w_ld_next = FULL;
          end
        end
      end
      FULL: begin
        if (w_commit) begin
          w_ld_next = LD_A;
        end
      end
      default: w_ld_next = LD_A;
    endcase
  end

  // Staging is cleared on reset so a partial triple can never leak into a
  // later commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_a <= '0;
      r_stage_b <= '0;
      r_stage_c <= '0;
    end else begin
      if (w_ld_a) r_stage_a <= in_data;
      if (w_ld_b) r_stage_b <= in_data;
      if (w_ld_c) r_stage_c <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq_err <= 1'b0;
    end else if (w_set_err) begin
      r_seq_err <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output FSM: commit, wait out the datapath latency, hold for the consumer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_state <= IDLE;
    end else begin
      r_out_state <= w_out_next;
    end
  end

  always_comb begin
    w_out_next = r_out_state;
    w_commit   = 1'b0;
    w_rv_set   = 1'b0;
    w_rv_clr   = 1'b0;
    unique case (r_out_state)
      IDLE: begin
        if (w_full) begin
          w_commit   = 1'b1;
          w_out_next = WAIT;
        end
      end
      WAIT: begin
        if (w_timer_done) begin
          w_rv_set   = 1'b1;
          w_out_next = HOLD;
        end
      end
      HOLD: begin
        if (r_res_valid && res_ready) begin
          w_rv_clr = 1'b1;
          // Back-to-back: the handshake edge doubles as the next commit.
          if (w_full) begin
            w_commit   = 1'b1;
            w_out_next = WAIT;
          end else begin
            w_out_next = IDLE;
          end
        end
      end
      default: w_out_next = IDLE;
    endcase
  end

  operand_triple_loader_latency_timer #(
    .DP_LATENCY (DP_LATENCY)
  ) u_latency_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_commit),
    .o_done (w_timer_done)
  );

  // a/b/c move only on a commit edge; everything downstream relies on that.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else if (w_commit) begin
      r_a <= r_stage_a;
      r_b <= r_stage_b;
      r_c <= r_stage_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
    end else if (w_rv_set) begin
      r_res_valid <= 1'b1;
    end else if (w_rv_clr) begin
      r_res_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign a         = r_a;
  assign b         = r_b;
  assign c         = r_c;
  assign res_valid = r_res_valid;
  assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_operand_triple_loader.sv
// ---------------------------------------------------------------------------
// tb_operand_triple_loader
//   Drives directed and randomized word streams into operand_triple_loader and
//   checks it every cycle against a transaction-level model: framing rules
//   build a queue of complete triples, a triple is committed on the first edge
//   the output slot is free, and res_valid follows DP_LATENCY edges later.
//   A small two-stage stand-in for the s4 datapath supplies x/z.
// ---------------------------------------------------------------------------
module tb_operand_triple_loader;

  localparam int DW  = 64;
  localparam int DPL = 2;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
  } trip_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [DW-1:0]        in_data = '0;
  logic                 in_first = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] a, b, c;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic                 seq_err;

  int n_vec = 0;
  int n_err = 0;
  int rr_mode = 1;  // 0: low, 1: high, 2: random

  operand_triple_loader #(.DATAWIDTH(DW), .DP_LATENCY(DPL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  // Stand-in datapath, two register stages, no enable.
  logic [DW-1:0] dp_g, dp_h, x, z;
  always @(posedge clk) begin
    dp_g <= a + b;
    dp_h <= b - c;
    x    <= dp_g ^ dp_h;
    z    <= dp_g + dp_h;
  end

  function automatic logic [DW-1:0] fx(input trip_t t);
    return (t.a + t.b) ^ (t.b - t.c);
  endfunction
  function automatic logic [DW-1:0] fz(input trip_t t);
    return (t.a + t.b) + (t.b - t.c);
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rr_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Reference model + per-cycle compare (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  trip_t         m_q[$];
  trip_t         m_cur = '0;
  int            m_part = 0;
  logic [DW-1:0] m_pa = '0, m_pb = '0;
  logic          m_err = 1'b0;
  logic          m_rv = 1'b0;
  logic          m_wait = 1'b0;
  int            m_since = 0;

  logic          p_rst = 1'b1;
  logic          p_acc = 1'b0;
  logic          p_first = 1'b0;
  logic          p_rr = 1'b0;
  logic [DW-1:0] p_data = '0;

  always @(negedge clk) begin
    logic stage_pre, free_pre;
    trip_t t;
    if (p_rst) begin
      m_q.delete();
      m_cur = '0; m_part = 0; m_err = 1'b0;
      m_rv = 1'b0; m_wait = 1'b0; m_since = 0;
    end else begin
      stage_pre = (m_q.size() != 0);
      free_pre  = (m_rv && p_rr) || (!m_rv && !m_wait);
      if (m_rv && p_rr) m_rv = 1'b0;
      if (m_wait) begin
        m_since++;
        if (m_since == DPL) begin m_rv = 1'b1; m_wait = 1'b0; end
      end
      if (stage_pre && free_pre) begin
        m_cur = m_q.pop_front();
        m_wait = 1'b1; m_since = 0;
      end
      if (p_acc) begin
        if (p_first) begin
          if (m_part != 0) m_err = 1'b1;
          m_pa = p_data; m_part = 1;
        end else if (m_part == 0) begin
          m_err = 1'b1;
        end else if (m_part == 1) begin
          m_pb = p_data; m_part = 2;
        end else begin
          t.a = m_pa; t.b = m_pb; t.c = p_data;
          m_q.push_back(t); m_part = 0;
        end
      end
    end
    chk("a", a, m_cur.a);
    chk("b", b, m_cur.b);
    chk("c", c, m_cur.c);
    chk("res_valid", 64'(res_valid), 64'(m_rv));
    chk("seq_err", 64'(seq_err), 64'(m_err));
    chk("in_ready", 64'(in_ready), 64'(!rst && m_q.size() == 0));
    if (m_rv) begin
      chk("x", x, fx(m_cur));
      chk("z", z, fz(m_cur));
    end
    p_rst   = rst;
    p_acc   = in_valid && in_ready && !rst;
    p_first = in_first;
    p_data  = in_data;
    p_rr    = res_ready;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called a little after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [DW-1:0] d, input logic f);
    int n = 0;
    in_data = d; in_first = f; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready stuck low for %0d cycles", n);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send3(input logic [DW-1:0] x0, input logic [DW-1:0] x1, input logic [DW-1:0] x2);
    send(x0, 1'b1); send(x1, 1'b0); send(x2, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_a", a, '0);
    chk("rst_c", c, '0);
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_seq_err", 64'(seq_err), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [DW-1:0] rnd64();
    case ($urandom_range(0, 9))
      0:       return 64'h8000_0000_0000_0000;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    // 1: single triple, latency pinned with literals
    rr_mode = 1;
    #1;
    do_reset();
    send3(64'd5, 64'd3, -64'sd2);
    tick(1);
    chk("t1_a", a, 64'd5);
    chk("t1_b", b, 64'd3);
    chk("t1_c", c, -64'sd2);
    chk("t1_rv_early", 64'(res_valid), 64'(0));
    tick(1);
    chk("t1_rv_still_low", 64'(res_valid), 64'(0));
    tick(1);
    chk("t1_rv", 64'(res_valid), 64'(1));
    chk("t1_x", x, 64'd13);
    chk("t1_z", z, 64'd13);
    tick(3);

    // 2: back-to-back triples with res_ready high
    send3(64'd100, 64'd200, 64'd300);
    send3(64'd400, 64'd500, 64'd600);
    tick(8);

    // 3: consumer stalls with a second triple staged
    rr_mode = 0;
    tick(1);
    do_reset();
    send3(64'd11, 64'd22, 64'd33);
    send3(64'd44, 64'd55, 64'd66);
    tick(10);
    chk("t3_in_ready_full", 64'(in_ready), 64'(0));
    chk("t3_rv_held", 64'(res_valid), 64'(1));
    chk("t3_a_held", a, 64'd11);
    rr_mode = 1;
    tick(1);
    chk("t3_a_next", a, 64'd44);
    chk("t3_rv_dropped", 64'(res_valid), 64'(0));
    tick(6);

    // 4: framing errors
    do_reset();
    send(64'd7, 1'b0);
    chk("t4_seq_err", 64'(seq_err), 64'(1));
    send(64'd1, 1'b1); send(64'd2, 1'b0); send(64'd9, 1'b1);
    send(64'd4, 1'b0); send(64'd6, 1'b0);
    tick(1);
    chk("t4_a", a, 64'd9);
    chk("t4_b", b, 64'd4);
    chk("t4_c", c, 64'd6);
    tick(5);

    // 5: reset mid-triple and mid-WAIT
    send(64'd100, 1'b1); send(64'd200, 1'b0);
    do_reset();
    send3(64'd1, 64'd2, 64'd3);
    tick(2);
    do_reset();
    send3(64'd10, 64'd20, 64'd30);
    tick(1);
    chk("t5_a", a, 64'd10);
    tick(5);

    // 6: boundary operands
    send3(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, '1);
    tick(1);
    chk("t6_a", a, 64'h8000_0000_0000_0000);
    chk("t6_b", b, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("t6_c", c, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(2);
    chk("t6_x", x, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("t6_z", z, 64'h7FFF_FFFF_FFFF_FFFF);
    tick(4);

    // Random phase: gaps, stalls, occasional framing errors and resets
    rr_mode = 2;
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      for (int k = 0; k < 3; k++) begin
        logic f;
        f = (k == 0);
        if ($urandom_range(0, 15) == 0) f = ~f;
        tick($urandom_range(0, 2));
        send(rnd64(), f);
      end
    end
    rr_mode = 1;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
